// File: rtl/iterative_right_shifter_pkg.sv
// Shared constants and FSM encoding for the iterative right shifter.
package iterative_right_shifter_pkg;

  localparam int unsigned RSH_WIDTH = 16;
  localparam int unsigned RSH_AMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_right_shifter_if.sv
// Start/busy/done handshake bundle for the iterative right shifter.
// The sticky signal exists only when RSHIFT_STICKY_EN is defined.
interface iterative_right_shifter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             arith;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef RSHIFT_STICKY_EN
  logic             sticky;

  modport master (output start, operand, amount, arith,
                  input  busy, done, result, sticky);
  modport slave  (input  start, operand, amount, arith,
                  output busy, done, result, sticky);
`else
  modport master (output start, operand, amount, arith,
                  input  busy, done, result);
  modport slave  (input  start, operand, amount, arith,
                  output busy, done, result);
`endif
endinterface

// File: rtl/iterative_right_shifter_right_shift_1b.sv
// Combinational single-position right shift with explicit fill bit.
module right_shift_1b
  import iterative_right_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = RSH_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_o
);

  assign data_o = {fill_i, data_i[WIDTH-1:1]};
  assign out_o  = data_i[0];

endmodule

// File: rtl/iterative_right_shifter.sv
// Multi-cycle logical/arithmetic right shifter, one bit per clock.
// Optional sticky (OR of shifted-out bits) enabled by RSHIFT_STICKY_EN.
module iterative_right_shifter
  import iterative_right_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = RSH_WIDTH,
  parameter int unsigned AMT_W = RSH_AMT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  iterative_right_shifter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;
  logic             accept;

  assign accept = (state_q == IDLE) && bus.start;

  right_shift_1b #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .fill_i (mode_q & data_q[WIDTH-1]),
    .data_o (shifted),
    .out_o  (shift_out)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // NOTE: defaulting every output first is what keeps this comb block latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.amount != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == AMT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on acceptance, step while shifting, hold otherwise.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (accept) begin
      data_d = bus.operand;
      cnt_d  = bus.amount;
      mode_d = bus.arith;
    end else if (state_q == SHIFT) begin
      data_d = shifted;
      cnt_d  = cnt_q - AMT_W'(1);
    end
  end

  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == DONE);
    bus.result = data_q;
  end

`ifdef RSHIFT_STICKY_EN
  logic sticky_q, sticky_d;

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  always_comb begin
    sticky_d = sticky_q;
    if (accept)                 sticky_d = 1'b0;
    else if (state_q == SHIFT)  sticky_d = sticky_q | shift_out;
  end

  assign bus.sticky = sticky_q;
`else
  // The shifted-out bit only feeds the sticky register.
  logic unused_shift_out;
  assign unused_shift_out = shift_out;
`endif

endmodule

// File: tb/tb_iterative_right_shifter.sv
// Scoreboard bench for iterative_right_shifter: driver pushes expectations,
// a negedge monitor compares result, done timing, busy and (optionally) sticky.
module tb_iterative_right_shifter;

  localparam int W = 16;
  localparam int A = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         stk;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  exp_t sb_q[$];

  iterative_right_shifter_if #(.WIDTH(W), .AMT_W(A)) bus ();

  iterative_right_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy must track an in-flight operation, done must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", 32'(bus.busy), 32'(sb_q.size() != 0));
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", 32'(bus.result), 32'(e.res));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef RSHIFT_STICKY_EN
          check("sticky", 32'(bus.sticky), 32'(e.stk));
`endif
        end
      end
    end
  end

  // Called #1 after a rising edge with the unit idle; returns #1 into cycle 1.
  task automatic issue(input logic [W-1:0] op, input logic [A-1:0] n, input logic ar,
                       input logic [W-1:0] exp_r, input logic exp_s);
    exp_t e;
    bus.start   = 1'b1;
    bus.operand = op;
    bus.amount  = n;
    bus.arith   = ar;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.operand = 16'hFFFF;
    bus.amount  = 4'hF;
    bus.arith   = ~ar;
    e.res = exp_r;
    e.stk = exp_s;
    e.cyc = cyc + int'(n);
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) return;
    end
    n_checks++;
    n_errs++;
    $display("FAIL timeout: %0d operations still pending, expected 0", sb_q.size());
    sb_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.operand = '0;
    bus.amount  = '0;
    bus.arith   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    @(posedge clk); #1;

    issue(16'h8000, 4'd4, 1'b1, 16'hF800, 1'b0);  wait_idle();
    issue(16'h8000, 4'd4, 1'b0, 16'h0800, 1'b0);  wait_idle();
    issue(16'h1234, 4'd0, 1'b1, 16'h1234, 1'b0);  wait_idle();
    issue(16'h8001, 4'd15, 1'b1, 16'hFFFF, 1'b1); wait_idle();
    issue(16'hB6C3, 4'd1, 1'b0, 16'h5B61, 1'b1);  wait_idle();
    issue(16'hB6C3, 4'd1, 1'b1, 16'hDB61, 1'b1);  wait_idle();
    issue(16'h7FFF, 4'd15, 1'b1, 16'h0000, 1'b1); wait_idle();

    // Result must hold while idle.
    repeat (3) @(posedge clk); #1;
    check("result_hold", 32'(bus.result), 32'h0000);

    // A start pulsed during SHIFT is ignored, not queued.
    issue(16'h00F0, 4'd8, 1'b0, 16'h0000, 1'b1);
    repeat (2) @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.operand = 16'hABCD;
    bus.amount  = 4'd1;
    bus.arith   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk); #1;

    // Reset mid-operation discards the in-flight shift.
    issue(16'hC3A5, 4'd10, 1'b1, 16'hFFF0, 1'b1);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_result", 32'(bus.result), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
`ifdef RSHIFT_STICKY_EN
    check("midreset_sticky", 32'(bus.sticky), 32'd0);
`endif
    repeat (12) @(posedge clk); #1;
    issue(16'h0100, 4'd8, 1'b0, 16'h0001, 1'b0);  wait_idle();

    repeat (3) @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
